// File: rtl/pixel_unpacker.sv
// AXI4-Stream RGB888 unpacker: three packed 32-bit words in, four 24-bit {r,g,b} pixels out.
// Tracks line position to flag early/missing tlast and tuser arriving mid-group.
module pixel_unpacker #(
  parameter int unsigned FRAME_WIDTH = 640,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        valid,
  input  logic        ready_in,
  output logic        sof,
  output logic        eol,
  output logic        line_err,
  output logic        sof_err
);

  localparam int unsigned WPL = FRAME_WIDTH * 3 / 4;
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPL - 1);

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;

  phase_e            phase_q, phase_d;
  logic [23:0]       hold_q, hold_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              term_q, term_d;
  logic [23:0]       px_q, px_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              line_err_q, line_err_d;
  logic              sof_err_q, sof_err_d;

  logic              adv;
  logic              tready_c;
  logic              beat;
  logic              resync;
  phase_e            phase_eff;
  logic [CNT_W-1:0]  pix_eff;
  logic [CNT_W-1:0]  word_eff;
  logic              emit;
  logic              force_eol;
  logic [23:0]       new_px;

  // tkeep carries no information for this sink
  logic unused_tkeep;
  assign unused_tkeep = ^in_stream_tkeep;

  // Decode, line tracking and output-register next state
  always_comb begin
    phase_d    = phase_q;
    hold_d     = hold_q;
    pix_cnt_d  = pix_cnt_q;
    word_cnt_d = word_cnt_q;
    term_d     = term_q;
    px_d       = px_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    eol_d      = eol_q;
    line_err_d = 1'b0;
    sof_err_d  = 1'b0;
    emit       = 1'b0;
    force_eol  = 1'b0;
    new_px     = '0;

    adv       = !valid_q || ready_in;
    tready_c  = (phase_q != P3) && adv;
    beat      = in_stream_tvalid && tready_c;
    resync    = beat && in_stream_tuser && (phase_q != P0);
    phase_eff = resync ? P0 : phase_q;
    pix_eff   = resync ? '0 : pix_cnt_q;
    word_eff  = resync ? '0 : word_cnt_q;

    if (adv) begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
    end

    if (beat) begin
      emit      = 1'b1;
      sof_d     = in_stream_tuser;
      sof_err_d = resync;
      case (phase_eff)
        P0: begin
          new_px  = in_stream_tdata[23:0];
          hold_d  = {16'h0000, in_stream_tdata[31:24]};
          phase_d = P1;
        end
        P1: begin
          new_px  = {in_stream_tdata[15:0], hold_q[7:0]};
          hold_d  = {8'h00, in_stream_tdata[31:16]};
          phase_d = P2;
        end
        default: begin
          new_px  = {in_stream_tdata[7:0], hold_q[15:0]};
          hold_d  = in_stream_tdata[31:8];
          phase_d = P3;
        end
      endcase
      // Early tlast closes the line after this beat's pixels (held p3 included)
      if (in_stream_tlast && (word_eff != LAST_WORD)) begin
        line_err_d = 1'b1;
        word_cnt_d = '0;
        if (phase_eff == P2) begin
          term_d = 1'b1;
        end else begin
          force_eol = 1'b1;
          phase_d   = P0;
        end
      end else if (word_eff == LAST_WORD) begin
        line_err_d = !in_stream_tlast;
        word_cnt_d = '0;
      end else begin
        word_cnt_d = word_eff + CNT_W'(1);
      end
    end else if (adv && (phase_q == P3)) begin
      emit      = 1'b1;
      new_px    = hold_q;
      phase_d   = P0;
      force_eol = term_q;
      term_d    = 1'b0;
    end

    if (emit) begin
      valid_d = 1'b1;
      px_d    = new_px;
      if (force_eol || (pix_eff == LAST_PIX)) begin
        eol_d     = 1'b1;
        pix_cnt_d = '0;
      end else begin
        pix_cnt_d = pix_eff + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      phase_q    <= P0;
      hold_q     <= '0;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      term_q     <= 1'b0;
      px_q       <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      line_err_q <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      term_q     <= term_d;
      px_q       <= px_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      line_err_q <= line_err_d;
      sof_err_q  <= sof_err_d;
    end
  end

  assign in_stream_tready = tready_c;
  assign r        = px_q[23:16];
  assign g        = px_q[15:8];
  assign b        = px_q[7:0];
  assign valid    = valid_q;
  assign sof      = sof_q;
  assign eol      = eol_q;
  assign line_err = line_err_q;
  assign sof_err  = sof_err_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker: vector table, ramp lines, stalls, early/missing tlast,
// mid-group tuser and mid-line reset.
module tb_pixel_unpacker;

  localparam int unsigned FW = 640;

  logic        aclk = 1'b0;
  logic        rst;
  logic [31:0] in_stream_tdata;
  logic [3:0]  in_stream_tkeep;
  logic        in_stream_tvalid;
  logic        in_stream_tready;
  logic        in_stream_tlast;
  logic        in_stream_tuser;
  logic [7:0]  r, g, b;
  logic        valid;
  logic        ready_in;
  logic        sof, eol, line_err, sof_err;

  always #5 aclk = ~aclk;

  pixel_unpacker #(.FRAME_WIDTH(FW), .CNT_W(16)) dut (
    .aclk(aclk), .rst(rst),
    .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
    .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
    .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
    .r(r), .g(g), .b(b), .valid(valid), .ready_in(ready_in),
    .sof(sof), .eol(eol), .line_err(line_err), .sof_err(sof_err)
  );

  int checks = 0;
  int failures = 0;

  // Observed traffic, written only by the monitor
  logic [23:0] act_px  [4096];
  logic        act_sof [4096];
  logic        act_eol [4096];
  int          act_n = 0;
  int          lerr_cnt = 0;
  int          serr_cnt = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [26:0] prev_out = '0;
  logic [26:0] cur_out;
  assign cur_out = {valid, sof, eol, r, g, b};

  // Expected pixels, written only by the main sequence
  logic [23:0] exp_px  [4096];
  logic        exp_sof [4096];
  logic        exp_eol [4096];
  int          exp_n = 0;
  int          act_base = 0;
  int          le0, se0, sv0;

  int rdy_mode = 0;

  typedef struct {
    logic [31:0] word;
    logic        user;
    logic [23:0] exp_a;
    logic        exp_sof;
    logic        has_b;
    logic [23:0] exp_b;
  } vec_t;
  vec_t vecs [6];

  always @(negedge aclk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (cur_out != prev_out)) stall_viol <= stall_viol + 1;
      prev_stall <= valid & ~ready_in;
      prev_out   <= cur_out;
      if (valid && ready_in && act_n < 4096) begin
        act_px[12'(act_n)]  <= {r, g, b};
        act_sof[12'(act_n)] <= sof;
        act_eol[12'(act_n)] <= eol;
        act_n <= act_n + 1;
      end
      if (line_err) lerr_cnt <= lerr_cnt + 1;
      if (sof_err)  serr_cnt <= serr_cnt + 1;
    end
  end

  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      ready_in = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ramp(input int n);
    logic [15:0] v;
    v = 16'(n);
    return {v[7:0], ~v[7:0], v[15:8]};
  endfunction

  task automatic push_exp(input logic [23:0] px, input logic s, input logic e);
    exp_px[12'(exp_n)]  = px;
    exp_sof[12'(exp_n)] = s;
    exp_eol[12'(exp_n)] = e;
    exp_n++;
  endtask

  task automatic start_test();
    act_base = act_n;
    exp_n    = 0;
    le0 = lerr_cnt;
    se0 = serr_cnt;
    sv0 = stall_viol;
  endtask

  task automatic do_reset(input string name);
    rdy_mode = 0;
    in_stream_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    rst = 1'b0;
    chk({name, "_valid"}, 32'(valid), 32'd0);
    chk({name, "_rgb"}, 32'({r, g, b}), 32'd0);
    chk({name, "_flags"}, 32'({sof, eol, line_err, sof_err}), 32'd0);
    chk({name, "_tready"}, 32'(in_stream_tready), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic u, input logic l, output int waits);
    logic got;
    in_stream_tdata  = d;
    in_stream_tuser  = u;
    in_stream_tlast  = l;
    in_stream_tvalid = 1'b1;
    waits = 0;
    got = 1'b0;
    while (!got) begin
      @(negedge aclk);
      if (in_stream_tready) begin
        got = 1'b1;
      end else begin
        waits++;
        if (waits > 200) begin
          checks++;
          failures++;
          $display("FAIL send_word_timeout actual=no_tready required=tready");
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $fatal(1, "input handshake stuck");
        end
      end
    end
    @(posedge aclk);
    #1;
    in_stream_tvalid = 1'b0;
    in_stream_tuser  = 1'b0;
    in_stream_tlast  = 1'b0;
  endtask

  // Pack a ramp line; wait_bad counts words whose tready wait differs from the 3-of-4 cadence
  task automatic send_line(input int npix, input bit user_first, input int last_word,
                           input bit gaps, output int wait_bad);
    logic [23:0] p [4];
    logic [31:0] wd [3];
    int w;
    int wt;
    w = 0;
    wait_bad = 0;
    for (int gi = 0; gi < npix / 4; gi++) begin
      for (int k = 0; k < 4; k++) begin
        p[k] = ramp(4 * gi + k);
        push_exp(p[k], user_first && gi == 0 && k == 0, (4 * gi + k) == npix - 1);
      end
      wd[0] = {p[1][7:0], p[0]};
      wd[1] = {p[2][15:0], p[1][23:8]};
      wd[2] = {p[3], p[2][23:16]};
      for (int k = 0; k < 3; k++) begin
        send_word(wd[k], user_first && w == 0, w == last_word, wt);
        if (!gaps && wt != ((w > 0 && w % 3 == 0) ? 1 : 0)) wait_bad++;
        w++;
        if (gaps && $urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) begin
            @(posedge aclk);
            #1;
          end
        end
      end
    end
  endtask

  task automatic wait_count(input string name, input int n);
    int cyc;
    cyc = 0;
    while ((act_n - act_base) < n && cyc < 20000) begin
      @(negedge aclk);
      cyc++;
    end
    repeat (8) @(negedge aclk);
    chk({name, "_count"}, 32'(act_n - act_base), 32'(n));
  endtask

  task automatic wait_and_compare(input string name);
    int n_act;
    int bad;
    int first;
    logic [11:0] ai;
    logic [11:0] ei;
    wait_count(name, exp_n);
    n_act = act_n - act_base;
    bad = 0;
    first = -1;
    for (int i = 0; i < exp_n && i < n_act; i++) begin
      ai = 12'(act_base + i);
      ei = 12'(i);
      if ({act_sof[ai], act_eol[ai], act_px[ai]} !== {exp_sof[ei], exp_eol[ei], exp_px[ei]}) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      ai = 12'(act_base + first);
      ei = 12'(first);
      $display("FAIL %s_seq idx=%0d actual=sof%b eol%b %h required=sof%b eol%b %h mismatches=%0d",
               name, first, act_sof[ai], act_eol[ai], act_px[ai],
               exp_sof[ei], exp_eol[ei], exp_px[ei], bad);
    end
  endtask

  initial begin
    int wt;
    int wb;
    int idx;
    rst = 1'b1;
    in_stream_tdata  = '0;
    in_stream_tkeep  = 4'hF;
    in_stream_tvalid = 1'b0;
    in_stream_tuser  = 1'b0;
    in_stream_tlast  = 1'b0;

    vecs[0] = '{32'h44332211, 1'b1, 24'h332211, 1'b1, 1'b0, 24'h000000};
    vecs[1] = '{32'h88776655, 1'b0, 24'h665544, 1'b0, 1'b0, 24'h000000};
    vecs[2] = '{32'hCCBBAA99, 1'b0, 24'h998877, 1'b0, 1'b1, 24'hCCBBAA};
    vecs[3] = '{32'h03020100, 1'b0, 24'h020100, 1'b0, 1'b0, 24'h000000};
    vecs[4] = '{32'h07060504, 1'b0, 24'h050403, 1'b0, 1'b0, 24'h000000};
    vecs[5] = '{32'h0B0A0908, 1'b0, 24'h080706, 1'b0, 1'b1, 24'h0B0A09};

    do_reset("rst0");

    // Byte-order vectors
    start_test();
    for (int i = 0; i < 6; i++) send_word(vecs[i].word, vecs[i].user, 1'b0, wt);
    wait_count("vec", 8);
    idx = act_base;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d_a", i), 32'({act_sof[12'(idx)], act_eol[12'(idx)], act_px[12'(idx)]}),
          32'({vecs[i].exp_sof, 1'b0, vecs[i].exp_a}));
      idx++;
      if (vecs[i].has_b) begin
        chk($sformatf("vec%0d_b", i), 32'({act_sof[12'(idx)], act_eol[12'(idx)], act_px[12'(idx)]}),
            32'({1'b0, 1'b0, vecs[i].exp_b}));
        idx++;
      end
    end
    chk("vec_errs", 32'((lerr_cnt - le0) + (serr_cnt - se0)), 32'd0);

    // Full ramp line at full rate
    do_reset("rst1");
    start_test();
    send_line(640, 1'b1, 479, 1'b0, wb);
    wait_and_compare("line");
    chk("line_tready_cadence", 32'(wb), 32'd0);
    chk("line_line_err", 32'(lerr_cnt - le0), 32'd0);
    chk("line_sof_err", 32'(serr_cnt - se0), 32'd0);

    // Two lines with random downstream stalls and input gaps
    do_reset("rst2");
    start_test();
    rdy_mode = 1;
    send_line(640, 1'b1, 479, 1'b1, wb);
    send_line(640, 1'b0, 479, 1'b1, wb);
    wait_and_compare("stall");
    rdy_mode = 0;
    chk("stall_stable", 32'(stall_viol - sv0), 32'd0);
    chk("stall_errs", 32'((lerr_cnt - le0) + (serr_cnt - se0)), 32'd0);

    // Early tlast on word 299, then a normal line
    do_reset("rst3");
    start_test();
    send_line(400, 1'b1, 299, 1'b0, wb);
    send_line(640, 1'b0, 479, 1'b0, wb);
    wait_and_compare("short");
    chk("short_line_err", 32'(lerr_cnt - le0), 32'd1);
    chk("short_sof_err", 32'(serr_cnt - se0), 32'd0);

    // Missing tlast on the last word
    do_reset("rst4");
    start_test();
    send_line(640, 1'b1, -1, 1'b0, wb);
    wait_and_compare("nolast");
    chk("nolast_line_err", 32'(lerr_cnt - le0), 32'd1);

    // tuser on a word arriving in P2
    do_reset("rst5");
    start_test();
    push_exp(24'h332211, 1'b1, 1'b0);
    push_exp(24'h665544, 1'b0, 1'b0);
    push_exp(24'h0E0D0C, 1'b1, 1'b0);
    push_exp(24'h11100F, 1'b0, 1'b0);
    push_exp(24'h141312, 1'b0, 1'b0);
    push_exp(24'h171615, 1'b0, 1'b0);
    send_word(32'h44332211, 1'b1, 1'b0, wt);
    send_word(32'h88776655, 1'b0, 1'b0, wt);
    send_word(32'h0F0E0D0C, 1'b1, 1'b0, wt);
    send_word(32'h13121110, 1'b0, 1'b0, wt);
    send_word(32'h17161514, 1'b0, 1'b0, wt);
    wait_and_compare("resync");
    chk("resync_sof_err", 32'(serr_cnt - se0), 32'd1);
    chk("resync_line_err", 32'(lerr_cnt - le0), 32'd0);

    // One-cycle reset while in P2
    do_reset("rst6");
    start_test();
    push_exp(24'h332211, 1'b1, 1'b0);
    push_exp(24'h665544, 1'b0, 1'b0);
    send_word(32'h44332211, 1'b1, 1'b0, wt);
    send_word(32'h88776655, 1'b0, 1'b0, wt);
    @(negedge aclk);
    #1;
    rst = 1'b1;
    @(posedge aclk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_tready", 32'(in_stream_tready), 32'd1);
    push_exp(24'h020100, 1'b0, 1'b0);
    push_exp(24'h050403, 1'b0, 1'b0);
    push_exp(24'h080706, 1'b0, 1'b0);
    push_exp(24'h0B0A09, 1'b0, 1'b0);
    send_word(32'h03020100, 1'b0, 1'b0, wt);
    send_word(32'h07060504, 1'b0, 1'b0, wt);
    send_word(32'h0B0A0908, 1'b0, 1'b0, wt);
    wait_and_compare("midrst");
    chk("midrst_errs", 32'((lerr_cnt - le0) + (serr_cnt - se0)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
